udma_ctrl_ext: RTL and testbench

Parametrised next-generation uDMA control unit on the uDMA config bus (periph slot 0).
- Holds per-peripheral clock-gate enables and drives the core clock-gate enable.
- Generates timed per-peripheral reset pulses.
- Routes incoming SoC events through a buffered FIFO to a configurable number of event outputs.
- Generalises fixed 4-output, unbuffered event routing to N_EVT_OUT outputs with a FIFO, and adds a counted reset-pulse engine.

---
 rtl/udma_ctrl_ext.sv | 171 +++++++++++++++++
 tb/tb_udma_ctrl_ext.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/udma_ctrl_ext.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : udma_ctrl_ext                                                 |
// | Purpose  : uDMA control unit with clock gates, timed peripheral resets   |
// |            and FIFO-buffered event routing to N_EVT_OUT outputs.         |
// | Options  : UDMA_CTRL_EVT_CNT_EN builds per-output event counters (0x10+k) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module udma_ctrl_ext #(
    parameter int N_PERIPHS      = 8,
    parameter int N_EVT_OUT      = 4,
    parameter int EVT_WIDTH      = 8,
    parameter int EVT_FIFO_DEPTH = 4,
    parameter int RST_CYCLES     = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [31:0]          cfg_data_i,
    input  logic [4:0]           cfg_addr_i,
    input  logic                 cfg_valid_i,
    input  logic                 cfg_rwn_i,
    output logic [31:0]          cfg_data_o,
    output logic                 cfg_ready_o,
    output logic [N_PERIPHS-1:0] cg_value_o,
    output logic                 cg_core_o,
    output logic [N_PERIPHS-1:0] rst_value_o,
    input  logic                 event_valid_i,
    input  logic [EVT_WIDTH-1:0] event_data_i,
    output logic                 event_ready_o,
    output logic [N_EVT_OUT-1:0] event_o
);

    localparam int PW  = $clog2(EVT_FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] C_RST_LOAD = RCW'(RST_CYCLES - 1);

    logic                 w_wr, w_wr_cg, w_wr_rst, w_wr_status;
    logic [N_PERIPHS-1:0] r_cg, r_rst_active;
    logic                 r_cg_core, r_bp;
    logic [EVT_WIDTH-1:0] r_fifo_mem [EVT_FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic                 w_full, w_push, w_pop;
    logic [EVT_WIDTH-1:0] r_sel_id [N_EVT_OUT];
    logic [N_EVT_OUT-1:0] r_sel_en, w_match, r_match, r_event;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_unused    = &{1'b0, cfg_data_i};
    assign w_wr        = cfg_valid_i & ~cfg_rwn_i;
    assign w_wr_cg     = w_wr && (cfg_addr_i == 5'h00);
    assign w_wr_rst    = w_wr && (cfg_addr_i == 5'h01);
    assign w_wr_status = w_wr && (cfg_addr_i == 5'h02);

    assign cfg_ready_o   = cfg_valid_i;
    assign cfg_data_o    = (cfg_valid_i & cfg_rwn_i) ? w_rdata : 32'h0;
    // Clock stays forced on while a reset pulse is running so the reset reaches the flops.
    assign cg_value_o    = r_cg | r_rst_active;
    assign cg_core_o     = r_cg_core;
    assign rst_value_o   = r_rst_active;
    assign event_o       = r_event;

    assign w_full        = (r_level == LW'(EVT_FIFO_DEPTH));
    assign event_ready_o = ~w_full;
    assign w_push        = event_valid_i & ~w_full;
    assign w_pop         = (r_level != '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cg      <= '0;
            r_cg_core <= 1'b0;
            r_bp      <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_match   <= '0;
            r_event   <= '0;
            for (int j = 0; j < EVT_FIFO_DEPTH; j++) r_fifo_mem[j] <= '0;
        end else begin
            if (w_wr_cg) r_cg <= cfg_data_i[N_PERIPHS-1:0];
            r_cg_core <= |cg_value_o;
            if (event_valid_i & w_full)
                r_bp <= 1'b1;
            else if (w_wr_status & cfg_data_i[16])
                r_bp <= 1'b0;
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= event_data_i;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_level <= r_level + 1'b1;
            else if (w_pop && !w_push)
                r_level <= r_level - 1'b1;
            // Two register stages give the push-to-pulse latency of two cycles.
            r_match <= w_match;
            r_event <= r_match;
        end
    end

    for (genvar i = 0; i < N_PERIPHS; i++) begin : g_rst
        logic [RCW-1:0] r_cnt;
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                r_rst_active[i] <= 1'b0;
                r_cnt           <= '0;
            end else if (w_wr_rst & cfg_data_i[i]) begin
                r_rst_active[i] <= 1'b1;
                r_cnt           <= C_RST_LOAD;
            end else if (r_rst_active[i]) begin
                if (r_cnt == '0)
                    r_rst_active[i] <= 1'b0;
                else
                    r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    for (genvar k = 0; k < N_EVT_OUT; k++) begin : g_sel
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                r_sel_en[k] <= 1'b0;
                r_sel_id[k] <= '0;
            end else if (w_wr && (cfg_addr_i == 5'(8 + k))) begin
                r_sel_en[k] <= cfg_data_i[31];
                r_sel_id[k] <= cfg_data_i[EVT_WIDTH-1:0];
            end
        end
        assign w_match[k] = w_pop & r_sel_en[k] & (r_sel_id[k] == r_fifo_mem[r_rd_ptr]);
    end

`ifdef UDMA_CTRL_EVT_CNT_EN
    logic [15:0] r_evt_cnt [N_EVT_OUT];
    for (genvar k = 0; k < N_EVT_OUT; k++) begin : g_cnt
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i)
                r_evt_cnt[k] <= '0;
            else if (w_wr && (cfg_addr_i == 5'(16 + k)))
                r_evt_cnt[k] <= '0;
            else if (r_event[k] && (r_evt_cnt[k] != 16'hFFFF))
                r_evt_cnt[k] <= r_evt_cnt[k] + 16'd1;
        end
    end
`endif

    always_comb begin
        w_rdata = 32'h0;
        case (cfg_addr_i)
            5'h00: w_rdata[N_PERIPHS-1:0] = r_cg;
            5'h01: w_rdata[N_PERIPHS-1:0] = r_rst_active;
            5'h02: begin
                w_rdata[7:0] = 8'(r_level);
                w_rdata[8]   = w_full;
                w_rdata[16]  = r_bp;
            end
            default: ;
        endcase
        for (int k = 0; k < N_EVT_OUT; k++) begin
            if (cfg_addr_i == 5'(8 + k)) begin
                w_rdata[31]             = r_sel_en[k];
                w_rdata[EVT_WIDTH-1:0]  = r_sel_id[k];
            end
`ifdef UDMA_CTRL_EVT_CNT_EN
            if (cfg_addr_i == 5'(16 + k)) w_rdata[15:0] = r_evt_cnt[k];
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udma_ctrl_ext.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_udma_ctrl_ext                                              |
// | Purpose  : directed self-checking bench for udma_ctrl_ext                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_udma_ctrl_ext;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] cfg_wdata = '0;
    logic [4:0]  cfg_addr = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_rwn = 1'b0;
    logic [31:0] cfg_rdata;
    logic        cfg_ready;
    logic [7:0]  cg_value;
    logic        cg_core;
    logic [7:0]  rst_value;
    logic        evt_valid = 1'b0;
    logic [7:0]  evt_data = '0;
    logic        evt_ready;
    logic [3:0]  evt_out;

    int checks = 0;
    int errors = 0;

    udma_ctrl_ext dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .cfg_data_i    (cfg_wdata),
        .cfg_addr_i    (cfg_addr),
        .cfg_valid_i   (cfg_valid),
        .cfg_rwn_i     (cfg_rwn),
        .cfg_data_o    (cfg_rdata),
        .cfg_ready_o   (cfg_ready),
        .cg_value_o    (cg_value),
        .cg_core_o     (cg_core),
        .rst_value_o   (rst_value),
        .event_valid_i (evt_valid),
        .event_data_i  (evt_data),
        .event_ready_o (evt_ready),
        .event_o       (evt_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; consumes exactly one rising edge.
    task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
        cfg_valid = 1'b1;
        cfg_rwn   = 1'b0;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_wdata = '0;
    endtask

    // Combinational read between edges; consumes no clock edge.
    task automatic cfg_read(input logic [4:0] addr, output logic [31:0] data, output logic rdy);
        cfg_valid = 1'b1;
        cfg_rwn   = 1'b1;
        cfg_addr  = addr;
        #1;
        data      = cfg_rdata;
        rdy       = cfg_ready;
        cfg_valid = 1'b0;
        cfg_rwn   = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] id);
        evt_valid = 1'b1;
        evt_data  = id;
        @(negedge clk);
        evt_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        rdy;
        logic [7:0]  ids     [6] = '{8'h11, 8'h22, 8'h33, 8'h22, 8'h11, 8'h33};
        logic [3:0]  exp_evt [6] = '{4'b0101, 4'b0010, 4'b1000, 4'b0010, 4'b0101, 4'b1000};
        logic [3:0]  want;

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        check("rst_cg_value", cg_value, 0);
        check("rst_cg_core", cg_core, 0);
        check("rst_rst_value", rst_value, 0);
        check("rst_event_o", evt_out, 0);
        check("rst_event_ready", evt_ready, 1);
        check("idle_cfg_data", cfg_rdata, 0);
        cfg_read(5'h02, rd, rdy);
        check("rst_status", rd, 32'h0);
        check("read_ready", rdy, 1);

        cfg_write(5'h00, 32'h05);
        check("cg_value_after_write", cg_value, 8'h05);
        check("cg_core_same_cycle", cg_core, 0);
        @(negedge clk);
        check("cg_core_delayed", cg_core, 1);
        cfg_read(5'h00, rd, rdy);
        check("cg_readback", rd, 32'h05);
        cfg_write(5'h00, 32'h0);
        check("cg_value_cleared", cg_value, 0);
        check("cg_core_lag", cg_core, 1);
        @(negedge clk);
        check("cg_core_cleared", cg_core, 0);

        // Plain 8-cycle pulse
        cfg_write(5'h01, 32'h02);
        check("rst_pulse_c0", rst_value, 8'h02);
        check("rst_cg_forced", cg_value, 8'h02);
        cfg_read(5'h01, rd, rdy);
        check("rst_readback", rd, 32'h02);
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            check("rst_pulse_hold", rst_value, 8'h02);
        end
        @(negedge clk);
        check("rst_pulse_end", rst_value, 0);
        check("rst_cg_release", cg_value, 0);

        // Re-write at the fourth edge extends the pulse to 12 cycles
        cfg_write(5'h01, 32'h02);
        repeat (3) @(negedge clk);
        cfg_write(5'h01, 32'h02);
        check("rst_ext_c4", rst_value, 8'h02);
        for (int c = 5; c < 12; c++) begin
            @(negedge clk);
            check("rst_ext_hold", rst_value, 8'h02);
        end
        @(negedge clk);
        check("rst_ext_end", rst_value, 0);

        cfg_write(5'h08, 32'h8000_0011);
        cfg_write(5'h0A, 32'h8000_0011);
        cfg_read(5'h08, rd, rdy);
        check("sel0_readback", rd, 32'h8000_0011);
        cfg_read(5'h05, rd, rdy);
        check("unmapped_read", rd, 0);

        push_one(8'h11);
        check("evt_lat0", evt_out, 0);
        cfg_read(5'h02, rd, rdy);
        check("status_level1", rd, 32'h1);
        @(negedge clk);
        check("evt_lat1", evt_out, 0);
        @(negedge clk);
        check("evt_lat2", evt_out, 4'b0101);
        @(negedge clk);
        check("evt_lat3", evt_out, 0);

        push_one(8'h12);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("evt_nomatch", evt_out, 0);
        end

        cfg_write(5'h09, 32'h8000_0022);
        cfg_write(5'h0B, 32'h8000_0033);
        for (int i = 0; i < 9; i++) begin
            if (i < 6) begin
                evt_valid = 1'b1;
                evt_data  = ids[i];
                check("burst_ready", evt_ready, 1);
            end else begin
                evt_valid = 1'b0;
            end
            @(negedge clk);
            want = 4'b0000;
            if (i >= 2 && i < 8) want = exp_evt[i-2];
            check("burst_evt", evt_out, want);
        end
        cfg_read(5'h02, rd, rdy);
        check("status_drained", rd, 32'h0);

`ifdef UDMA_CTRL_EVT_CNT_EN
        cfg_write(5'h10, 32'h0);
        evt_valid = 1'b1;
        evt_data  = 8'h11;
        repeat (3) @(negedge clk);
        evt_valid = 1'b0;
        repeat (4) @(negedge clk);
        cfg_read(5'h10, rd, rdy);
        check("cnt_three", rd, 32'd3);
        cfg_write(5'h10, 32'h0);
        cfg_read(5'h10, rd, rdy);
        check("cnt_cleared", rd, 32'd0);
`else
        cfg_read(5'h10, rd, rdy);
        check("cnt_absent", rd, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
